// File: rtl/hex_display_driver.sv
// Multi-digit 7-segment driver: registered value with load/ready handshake,
// leading-zero blanking and tick-timed BLINK / SCROLL / FREEZE display modes.
module hex_display_driver #(
    parameter int DIGITS   = 6,
    parameter int TICK_DIV = 25_000_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                load,
    input  logic [4*DIGITS-1:0] value,
    input  logic [1:0]          mode,
    output logic                ready,
    output logic                tick,
    output logic [7*DIGITS-1:0] hex
);

    localparam int OW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        M_STATIC = 2'b00,
        M_BLINK  = 2'b01,
        M_SCROLL = 2'b10,
        M_FREEZE = 2'b11
    } mode_e;

    logic [4*DIGITS-1:0] value_q, value_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tick_q, tick_d;
    logic                phase_q, phase_d;
    logic [OW-1:0]       offset_q, offset_d;
    mode_e               mode_q, mode_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;

    logic                accept;
    logic [DIGITS-1:0]   keep;
    logic [7*DIGITS-1:0] static_pat, scroll_pat;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign ready  = !((mode_q == M_SCROLL) && (offset_q != '0));
    assign accept = load & ready;
    assign tick   = tick_q;
    assign hex    = hex_q;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        cnt_d    = (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + CW'(1);
        tick_d   = (cnt_q == CW'(TICK_DIV - 1));
        value_d  = accept ? value : value_q;
        mode_d   = mode_e'(mode);
        phase_d  = phase_q;
        offset_d = offset_q;

        if (mode_e'(mode) != mode_q) begin
            phase_d  = 1'b0;
            offset_d = '0;
        end else if (tick_q) begin
            if (mode_q == M_BLINK) begin
                phase_d = ~phase_q;
            end
            if (mode_q == M_SCROLL) begin
                offset_d = (offset_q == OW'(DIGITS - 1)) ? '0 : offset_q + OW'(1);
            end
        end
    end

    // Digit i stays lit if it or any higher digit is nonzero; digit 0 always lit.
    always_comb begin
        logic seen;
        int   idx;
        seen       = 1'b0;
        idx        = 0;
        keep       = '0;
        static_pat = '1;
        scroll_pat = '1;
        hex_d      = hex_q;

        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (value_q[4*i +: 4] != 4'h0);
            keep[i] = seen || (i == 0) || !BLANK_LZ;
        end

        for (int i = 0; i < DIGITS; i++) begin
            idx = i + int'(offset_q);
            if (idx >= DIGITS) begin
                idx = idx - DIGITS;
            end
            static_pat[7*i +: 7] = keep[i] ? seg7(value_q[4*i +: 4]) : 7'h7F;
            scroll_pat[7*i +: 7] = seg7(value_q[4*idx +: 4]);
        end

        case (mode_q)
            M_STATIC: hex_d = static_pat;
            M_BLINK:  hex_d = phase_q ? '1 : static_pat;
            M_SCROLL: hex_d = scroll_pat;
            default:  hex_d = hex_q;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            value_q  <= '0;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            phase_q  <= 1'b0;
            offset_q <= '0;
            mode_q   <= M_STATIC;
            hex_q    <= '1;
        end else begin
            value_q  <= value_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            phase_q  <= phase_d;
            offset_q <= offset_d;
            mode_q   <= mode_d;
            hex_q    <= hex_d;
        end
    end

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver (DIGITS=4, TICK_DIV=4, BLANK_LZ=1).
module tb_hex_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [1:0]  mode;
    logic        ready;
    logic        tick;
    logic [27:0] hex;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [27:0] exp_q[$];

    localparam logic [27:0] ALL_BLANK = 28'hFFFFFFF;
    localparam logic [27:0] PAT_ZERO  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [27:0] PAT_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
    localparam logic [27:0] PAT_4123  = {7'h19, 7'h79, 7'h24, 7'h30};

    hex_display_driver #(.DIGITS(4), .TICK_DIV(4), .BLANK_LZ(1'b1)) dut (
        .CLOCK_50(clk), .reset(reset), .load(load), .value(value),
        .mode(mode), .ready(ready), .tick(tick), .hex(hex)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic logic [27:0] static_pat(input logic [15:0] v);
        int          top = 0;
        logic [27:0] r = '1;
        for (int i = 0; i < 4; i++) if (v[4*i +: 4] != 4'h0) top = i;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = (i > top) ? 7'h7F : seg7(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [27:0] rot_pat(input logic [15:0] v, input int off);
        logic [27:0] r = '1;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = seg7(v[4*((i + off) % 4) +: 4]);
        return r;
    endfunction

    function automatic logic tick_now();
        return (cyc % 4 == 0) && (cyc != 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (reset) cyc = 0;
        else cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; value = '0; mode = 2'b00;
        step(); step();
        checks++; if (hex !== ALL_BLANK) begin errors++; $display("FAIL reset_hex: got %h expected %h", hex, ALL_BLANK); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
        reset = 1'b0;
        exp_q.push_back(PAT_ZERO);
        step();
        checks++; if (hex !== exp_q[0]) begin errors++; $display("FAIL post_reset_hex: got %h expected %h", hex, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_static();
        logic [15:0] vals [4] = '{16'h00A3, 16'h0000, 16'h0F05, 16'h8000};
        logic [27:0] pats [4] = '{{7'h7F, 7'h7F, 7'h08, 7'h30}, PAT_ZERO,
                                  {7'h7F, 7'h0E, 7'h40, 7'h12}, {7'h00, 7'h40, 7'h40, 7'h40}};
        logic [27:0] e;
        for (int k = 0; k < 4; k++) begin
            value = vals[k]; load = 1'b1;
            exp_q.push_back(pats[k]);
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL static_ready: got %b expected 1", ready); end
            step();
            load = 1'b0;
            step();
            e = exp_q.pop_front();
            checks++; if (hex !== e) begin errors++; $display("FAIL static_%0d: got %h expected %h", k, hex, e); end
        end
    endtask

    task automatic test_tick();
        int highs = 0;
        logic t;
        for (int c = 0; c < 16; c++) begin
            load = 1'($urandom_range(0, 1));
            value = 16'($urandom);
            mode = 2'($urandom_range(0, 3));
            t = tick_now();
            checks++; if (tick !== t) begin errors++; $display("FAIL tick_cycle: got %b expected %b at cycle %0d", tick, t, cyc); end
            if (tick === 1'b1) highs++;
            step();
        end
        checks++; if (highs != 4) begin errors++; $display("FAIL tick_count: got %0d expected 4", highs); end
        load = 1'b0; mode = 2'b00;
        step(); step();
    endtask

    task automatic test_blink();
        logic [1:0]  mq = 2'b00;
        logic        ph = 1'b0, nph;
        logic [27:0] e;
        value = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        step();
        checks++; if (hex !== PAT_1234) begin errors++; $display("FAIL blink_preload: got %h expected %h", hex, PAT_1234); end
        mode = 2'b01;
        for (int c = 0; c < 20; c++) begin
            exp_q.push_back((mq == 2'b01 && ph) ? ALL_BLANK : PAT_1234);
            if (mode != mq) nph = 1'b0;
            else if (tick_now() && mq == 2'b01) nph = ~ph;
            else nph = ph;
            step();
            mq = mode; ph = nph;
            e = exp_q.pop_front();
            checks++; if (hex !== e) begin errors++; $display("FAIL blink_cycle: got %h expected %h at cycle %0d", hex, e, cyc); end
        end
        mode = 2'b00;
        step(); step();
        checks++; if (hex !== PAT_1234) begin errors++; $display("FAIL blink_restore: got %h expected %h", hex, PAT_1234); end
    endtask

    task automatic test_scroll();
        logic [1:0]  mq = 2'b00;
        int          off = 0, noff;
        logic [15:0] vq = 16'h1234, nvq;
        logic        rdy;
        logic [27:0] e;
        bit          saw_busy = 1'b0, saw_4123 = 1'b0;
        mode = 2'b10; load = 1'b0; value = 16'hFFFF;
        for (int c = 0; c < 48; c++) begin
            rdy = !(mq == 2'b10 && off != 0);
            checks++; if (ready !== rdy) begin errors++; $display("FAIL scroll_ready: got %b expected %b at cycle %0d", ready, rdy, cyc); end
            if (!rdy) saw_busy = 1'b1;
            exp_q.push_back((mq == 2'b10) ? rot_pat(vq, off) : static_pat(vq));
            nvq = (load && rdy) ? value : vq;
            if (mode != mq) noff = 0;
            else if (tick_now() && mq == 2'b10) noff = (off == 3) ? 0 : off + 1;
            else noff = off;
            step();
            mq = mode; off = noff; vq = nvq;
            e = exp_q.pop_front();
            checks++; if (hex !== e) begin errors++; $display("FAIL scroll_cycle: got %h expected %h at cycle %0d", hex, e, cyc); end
            if (hex === PAT_4123) saw_4123 = 1'b1;
            if (off != 0 && vq != 16'hFFFF) load = 1'b1;
            if (vq == 16'hFFFF) load = 1'b0;
        end
        checks++; if (!saw_busy) begin errors++; $display("FAIL scroll_busy: got never-busy expected ready=0 during pass"); end
        checks++; if (!saw_4123) begin errors++; $display("FAIL scroll_4123: got absent expected %h seen", PAT_4123); end
        checks++; if (hex !== {4{7'h0E}}) begin errors++; $display("FAIL scroll_captured: got %h expected %h", hex, {4{7'h0E}}); end
    endtask

    task automatic test_freeze();
        logic [27:0] e;
        mode = 2'b00; load = 1'b0;
        step(); step();
        value = 16'h0012; load = 1'b1;
        exp_q.push_back({7'h7F, 7'h7F, 7'h79, 7'h24});
        step();
        load = 1'b0;
        step();
        checks++; if (hex !== exp_q[0]) begin errors++; $display("FAIL freeze_pre: got %h expected %h", hex, exp_q[0]); end
        mode = 2'b11;
        step(); step();
        value = 16'h0099; load = 1'b1;
        step();
        load = 1'b0;
        step(); step();
        e = exp_q.pop_front();
        checks++; if (hex !== e) begin errors++; $display("FAIL freeze_hold: got %h expected %h", hex, e); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL freeze_ready: got %b expected 1", ready); end
        mode = 2'b00;
        exp_q.push_back({7'h7F, 7'h7F, 7'h10, 7'h10});
        step(); step();
        e = exp_q.pop_front();
        checks++; if (hex !== e) begin errors++; $display("FAIL freeze_release: got %h expected %h", hex, e); end
    endtask

    task automatic test_reset_mid();
        mode = 2'b10;
        for (int i = 0; i < 24; i++) begin
            if (ready === 1'b0) break;
            step();
        end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_wait: got ready=%b expected 0 within 24 cycles", ready); end
        reset = 1'b1;
        step();
        checks++; if (hex !== ALL_BLANK) begin errors++; $display("FAIL midreset_hex: got %h expected %h", hex, ALL_BLANK); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", ready); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL midreset_tick: got %b expected 0", tick); end
        reset = 1'b0; mode = 2'b00;
        step();
        checks++; if (hex !== PAT_ZERO) begin errors++; $display("FAIL midreset_after: got %h expected %h", hex, PAT_ZERO); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midreset_after_ready: got %b expected 1", ready); end
    endtask

    initial begin
        test_reset();
        test_static();
        test_tick();
        test_blink();
        test_scroll();
        test_freeze();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
